dice_roll_ctrl: RTL and testbench

- Game sequencer for the dice display. Consumes single-cycle debounced button pulses: roll_tick and clr_tick.
- Runs a timed "spinning die" sequence: the face value advances every SPIN_DIV clocks for SPIN_STEPS steps, then settles.
- Reports the result, a completion pulse and a saturating roll counter to the display/score logic.
- Randomness comes from a free-running mod-6 counter sampled at the instant the roll button is pressed.

---
 rtl/dice_roll_if.sv | 19 +
 rtl/dice_roll_ctrl.sv | 108 ++++++++++
 tb/tb_dice_roll_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dice_roll_if.sv
// Button-pulse inputs and display/score outputs of the dice sequencer.
interface dice_roll_if;
  logic       roll_tick;
  logic       clr_tick;
  logic [2:0] die_val;
  logic       rolling;
  logic       done_pulse;
  logic [7:0] roll_count;

  modport master (
    output roll_tick, clr_tick,
    input  die_val, rolling, done_pulse, roll_count
  );

  modport slave (
    input  roll_tick, clr_tick,
    output die_val, rolling, done_pulse, roll_count
  );
endinterface

// File: rtl/dice_roll_ctrl.sv
// Dice sequencer: seeds from a free-running mod-6 counter on roll, spins the
// face SPIN_STEPS times at SPIN_DIV clocks per step, then settles and counts.
//
// state | meaning
// IDLE  | blank or cleared, waiting for roll_tick
// SPIN  | face advancing every SPIN_DIV clocks, buttons ignored
// DONE  | result held, waiting for roll_tick or clr_tick
module dice_roll_ctrl #(
  parameter int SPIN_DIV   = 5_000_000,
  parameter int SPIN_STEPS = 12,
  parameter int DIV_W      = 23,
  parameter int STEP_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  dice_roll_if.slave  io
);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SPIN_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SPIN_STEPS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SPIN = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [2:0]        free_q, free_d;
  logic [2:0]        die_q, die_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              rolling_q, rolling_d;
  logic              done_q, done_d;
  logic [7:0]        cnt_q, cnt_d;

  function automatic logic [2:0] next_face(input logic [2:0] f);
    return (f == 3'd6) ? 3'd1 : f + 3'd1;
  endfunction

  always_comb begin
    free_d    = (free_q == 3'd5) ? 3'd0 : free_q + 3'd1;
    state_d   = state_q;
    die_d     = die_q;
    div_d     = div_q;
    step_d    = step_q;
    rolling_d = rolling_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        // Clear wins over roll when both buttons land in the same cycle.
        if (io.clr_tick) begin
          state_d   = IDLE;
          die_d     = 3'd0;
          cnt_d     = 8'd0;
          rolling_d = 1'b0;
        end else if (io.roll_tick) begin
          state_d   = SPIN;
          rolling_d = 1'b1;
          die_d     = free_q + 3'd1;
          div_d     = '0;
          step_d    = '0;
        end
      end
      SPIN: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          die_d  = next_face(die_q);
          step_d = step_q + 1'b1;
          if (step_q == STEP_LAST) begin
            state_d   = DONE;
            rolling_d = 1'b0;
            done_d    = 1'b1;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      free_q    <= 3'd0;
      die_q     <= 3'd0;
      div_q     <= '0;
      step_q    <= '0;
      rolling_q <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      free_q    <= free_d;
      die_q     <= die_d;
      div_q     <= div_d;
      step_q    <= step_d;
      rolling_q <= rolling_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

  assign io.die_val    = die_q;
  assign io.rolling    = rolling_q;
  assign io.done_pulse = done_q;
  assign io.roll_count = cnt_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Scoreboard bench for dice_roll_ctrl: dut_a (SPIN_DIV=4, SPIN_STEPS=3) checks
// every output change against queued events; dut_b (2,1) covers count saturation.
module tb_dice_roll_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dice_roll_if ifa ();
  dice_roll_if ifb ();

  dice_roll_ctrl #(.SPIN_DIV(4), .SPIN_STEPS(3), .DIV_W(2), .STEP_W(2)) dut_a (
    .clk(clk), .rst(rst), .io(ifa)
  );
  dice_roll_ctrl #(.SPIN_DIV(2), .SPIN_STEPS(1), .DIV_W(1), .STEP_W(1)) dut_b (
    .clk(clk), .rst(rst), .io(ifb)
  );

  typedef struct {
    int          cyc;
    logic [12:0] obs;
  } ev_t;

  ev_t         qa[$];
  int          qb[$];
  logic [12:0] qs_got[$];
  logic [12:0] qs_exp[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          b_done   = 0;
  logic [12:0] prev_a   = '0;
  logic        end_req  = 1'b0;
  logic        end_done = 1'b0;

  // {die_val, rolling, done_pulse, roll_count}
  function automatic logic [12:0] mk(int d, logic r, logic p, int c);
    return {3'(d), r, p, 8'(c)};
  endfunction

  task automatic push_a(int c, logic [12:0] o);
    ev_t e;
    e.cyc = c;
    e.obs = o;
    qa.push_back(e);
  endtask

  // Full spin on dut_a: seed shown at base, one face step every 4 cycles,
  // settle with done_pulse at base+12, pulse drops at base+13.
  task automatic push_spin(int base, int seed, int cnt0);
    int fin;
    for (int k = 0; k < 3; k++)
      push_a(base + 4 * k, mk(((seed - 1 + k) % 6) + 1, 1'b1, 1'b0, cnt0));
    fin = ((seed - 1 + 3) % 6) + 1;
    push_a(base + 12, mk(fin, 1'b0, 1'b1, cnt0 + 1));
    push_a(base + 13, mk(fin, 1'b0, 1'b0, cnt0 + 1));
  endtask

  always @(negedge clk) begin
    logic [12:0] obs_a;
    logic [12:0] g, x;
    ev_t         e;
    int          eb;
    obs_a = {ifa.die_val, ifa.rolling, ifa.done_pulse, ifa.roll_count};
    if (obs_a !== prev_a) begin
      n_checks++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL a_event cyc=%0d got die=%0d rol=%0b done=%0b cnt=%0d, required no change",
                 cyc, obs_a[12:10], obs_a[9], obs_a[8], obs_a[7:0]);
      end else begin
        e = qa.pop_front();
        if (e.cyc != cyc || e.obs !== obs_a) begin
          n_fail++;
          $display("FAIL a_event got cyc=%0d die=%0d rol=%0b done=%0b cnt=%0d, required cyc=%0d die=%0d rol=%0b done=%0b cnt=%0d",
                   cyc, obs_a[12:10], obs_a[9], obs_a[8], obs_a[7:0],
                   e.cyc, e.obs[12:10], e.obs[9], e.obs[8], e.obs[7:0]);
        end
      end
      prev_a = obs_a;
    end
    if (ifb.done_pulse === 1'b1) begin
      b_done++;
      n_checks++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL b_done unexpected pulse cnt=%0d", ifb.roll_count);
      end else begin
        eb = qb.pop_front();
        if (int'(ifb.roll_count) != eb) begin
          n_fail++;
          $display("FAIL b_count got=%0d required=%0d", ifb.roll_count, eb);
        end
      end
      n_checks++;
      if (!(ifb.die_val >= 3'd1 && ifb.die_val <= 3'd6)) begin
        n_fail++;
        $display("FAIL b_die_range got=%0d required 1..6", ifb.die_val);
      end
    end
    while (qs_got.size() > 0) begin
      g = qs_got.pop_front();
      x = qs_exp.pop_front();
      n_checks++;
      if (g !== x) begin
        n_fail++;
        $display("FAIL async_reset got=%h required=%h", g, x);
      end
    end
    if (end_req && !end_done) begin
      end_done = 1'b1;
      n_checks++;
      if (qa.size() != 0) begin
        n_fail++;
        $display("FAIL a_missing got %0d events pending, required 0", qa.size());
      end
      n_checks++;
      if (qb.size() != 0 || b_done != 260) begin
        n_fail++;
        $display("FAIL b_pulses got=%0d pending=%0d, required 260 pending=0", b_done, qb.size());
      end
      n_checks++;
      if (ifb.roll_count !== 8'd255) begin
        n_fail++;
        $display("FAIL b_saturate got=%0d required=255", ifb.roll_count);
      end
    end
  end

  initial begin
    ifa.roll_tick = 1'b0;
    ifa.clr_tick  = 1'b0;
    ifb.roll_tick = 1'b0;
    ifb.clr_tick  = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;                                   // release: free_cnt = k mod 6 after k-th edge
    repeat (20) @(negedge clk);

    // Roll with free_cnt = 20 mod 6 = 2 -> seed 3, final 6.
    push_spin(cyc + 1, 3, 0);
    ifa.roll_tick = 1'b1;
    @(negedge clk);
    ifa.roll_tick = 1'b0;
    repeat (15) @(negedge clk);

    push_a(cyc + 1, mk(0, 1'b0, 1'b0, 0));
    ifa.clr_tick = 1'b1;
    @(negedge clk);
    ifa.clr_tick = 1'b0;
    repeat (3) @(negedge clk);

    // free_cnt = 40 mod 6 = 4 -> seed 5, final 2; buttons hammered mid-spin.
    push_spin(cyc + 1, 5, 0);
    ifa.roll_tick = 1'b1;
    @(negedge clk);
    for (int k = 41; k < 53; k++) begin
      ifa.roll_tick = (k % 2 == 0);
      ifa.clr_tick  = (k % 3 == 0);
      @(negedge clk);
    end
    ifa.roll_tick = 1'b0;
    ifa.clr_tick  = 1'b0;
    repeat (3) @(negedge clk);

    // free_cnt = 56 mod 6 = 2 -> seed 3, final 6, roll from DONE.
    push_spin(cyc + 1, 3, 1);
    ifa.roll_tick = 1'b1;
    @(negedge clk);
    ifa.roll_tick = 1'b0;
    repeat (15) @(negedge clk);

    // Simultaneous roll and clear in DONE: clear wins.
    push_a(cyc + 1, mk(0, 1'b0, 1'b0, 0));
    ifa.roll_tick = 1'b1;
    ifa.clr_tick  = 1'b1;
    @(negedge clk);
    ifa.roll_tick = 1'b0;
    ifa.clr_tick  = 1'b0;
    repeat (3) @(negedge clk);

    // free_cnt = 76 mod 6 = 4 -> seed 5; aborted by reset after one step.
    push_a(cyc + 1, mk(5, 1'b1, 1'b0, 0));
    push_a(cyc + 5, mk(6, 1'b1, 1'b0, 0));
    ifa.roll_tick = 1'b1;
    @(negedge clk);
    ifa.roll_tick = 1'b0;
    repeat (5) @(negedge clk);
    push_a(cyc + 1, mk(0, 1'b0, 1'b0, 0));
    #2 rst = 1'b1;
    #1;
    qs_got.push_back({ifa.die_val, ifa.rolling, ifa.done_pulse, ifa.roll_count});
    qs_exp.push_back(mk(0, 1'b0, 1'b0, 0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Third edge after release samples free_cnt = 2 -> seed 3.
    push_spin(cyc + 1, 3, 0);
    ifa.roll_tick = 1'b1;
    @(negedge clk);
    ifa.roll_tick = 1'b0;
    repeat (16) @(negedge clk);

    // dut_b: 3-cycle rolls back to back, count saturates at 255.
    for (int i = 0; i < 260; i++) begin
      qb.push_back((i + 1 > 255) ? 255 : i + 1);
      ifb.roll_tick = 1'b1;
      @(negedge clk);
      ifb.roll_tick = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    end_req = 1'b1;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
